wb_ext_rr_arbiter: RTL and testbench
====================================

Name: wb_ext_rr_arbiter

Overview:
Round-robin Wishbone B3 arbiter that shares one external memory/peripheral slave among the per-tile external Wishbone master ports of a multi-tile compute system. It sits between the tiles' flattened wb_ext_* buses and a single off-chip or shared slave. It holds a grant for a whole bus cycle, including bursts, and guards the slave with a response-timeout counter.

Parameters:
NUM_MASTERS, 9, number of tile master ports (>=2)
ADDR_WIDTH, 32, address width per master
DATA_WIDTH, 32, data width per master; byte-select width is DATA_WIDTH/8
TIMEOUT, 255, cycles of unanswered s_stb before an error is forced; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  master addresses; slice i = [(i+1)*ADDR_WIDTH-1:i*ADDR_WIDTH]
m_dat_i  in  NUM_MASTERS*DATA_WIDTH  master write data
m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  byte selects
m_cyc_i, m_stb_i, m_we_i, m_cab_i  in  NUM_MASTERS each  per-master control
m_cti_i  in  NUM_MASTERS*3  cycle type identifiers
m_bte_i  in  NUM_MASTERS*2  burst type extensions
m_ack_o, m_rty_o, m_err_o  out  NUM_MASTERS each  per-master responses
m_dat_o  out  NUM_MASTERS*DATA_WIDTH  read data; slave data goes to every slice
s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cab_o, s_cti_o, s_bte_o  out  matching widths  muxed slave request
s_ack_i, s_rty_i, s_err_i  in  1 each  slave responses
s_dat_i  in  DATA_WIDTH  slave read data
grant_o  out  NUM_MASTERS  one-hot current grant; all zero when idle
busy_o  out  1  high in ACTIVE state

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, grant=0, rr_ptr=0, timeout counter=0.
  - All s_* control outputs, m_ack/rty/err, grant_o and busy_o are 0.
- IDLE:
  - s_cyc_o=s_stb_o=0; all m_ack/rty/err=0.
  - If any m_cyc_i[i]=1, select the first i with m_cyc_i[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
  - Register the selection as the grant and move to ACTIVE on the next edge. Arbitration latency is 1 cycle.
  - If no m_cyc_i is set, stay in IDLE.
- ACTIVE, grant g:
  - s_* request outputs are a combinational pass-through of master g's slice (adr, dat, sel, cyc, stb, we, cab, cti, bte).
  - m_ack_o[g]=s_ack_i, m_rty_o[g]=s_rty_i, m_err_o[g]=s_err_i. Response outputs for every other master are 0.
  - m_dat_o: every slice = s_dat_i; validity is qualified by ack.
  - Grant is held while m_cyc_i[g]=1. This covers incrementing/constant bursts (cti 001/010) and stb gaps within one cycle; no pre-emption.
  - When m_cyc_i[g]=0 (including the same cycle as the final ack): next state IDLE, rr_ptr=(g+1) mod NUM_MASTERS, grant cleared.
  - This guarantees at least one idle cycle between grants.
- Timeout (TIMEOUT>0):
  - The counter increments each ACTIVE cycle with s_stb_o=1 and s_ack_i|s_rty_i|s_err_i=0.
  - It clears on any response, on stb low, or on leaving ACTIVE.
  - When the counter equals TIMEOUT: in that cycle m_err_o[g]=1, s_cyc_o=s_stb_o=0, slave responses are ignored, and the counter clears. State stays ACTIVE until the master drops cyc.
  - The counter is 8..32 bits, sized $clog2(TIMEOUT+1), and saturates at TIMEOUT.
- rr_ptr wraps from NUM_MASTERS-1 to 0.
- A master asserting cyc while another holds the grant waits without any response.
- Reset mid-transaction: all outputs drop to 0 immediately (async). After release, arbitration restarts from master 0.

Test Plan:
- Single read: m_cyc/stb[2]=1, adr=0x1000, slave acks with dat=0xDEADBEEF 2 cycles after s_stb -> grant_o=0x004 one cycle after request; m_ack_o[2] pulses once with m_dat_o slice 2=0xDEADBEEF; idle cycle after cyc drops.
- Contention: masters 0 and 3 request in the same cycle after reset -> master 0 is served first; after it drops cyc, grant_o=0x008 following one idle cycle.
- Fairness: all 9 masters hold cyc continuously, each doing a single acked access -> grants in order 0,1,...,8,0; no master is granted twice before all others.
- Burst hold: master 5 issues a 4-beat cti=010 burst while master 1 requests -> all 4 acks go to master 5, then master 1 is granted; m_ack_o[1] stays 0 throughout.
- Timeout: TIMEOUT=16, slave never responds to master 4 -> m_err_o[4]=1 exactly 16 cycles after s_stb rises; s_stb_o=0 that cycle.
- Reset mid-burst: assert rst during beat 2 -> s_cyc_o, grant_o and busy_o are 0 in the same cycle; after release, a request from master 7 is granted normally with rr_ptr=0.

Source files
------------

// File: rtl/wb_ext_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: shares one slave among NUM_MASTERS tile ports,
// holds the grant for a full bus cycle and forces an error on unanswered strobes.
module wb_ext_rr_arbiter #(
    parameter int NUM_MASTERS = 9,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS-1:0]            m_cab_i,
    input  logic [NUM_MASTERS*3-1:0]          m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]          m_bte_i,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_rty_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic [DATA_WIDTH/8-1:0]           s_sel_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic                              s_cab_o,
    output logic [2:0]                        s_cti_o,
    output logic [1:0]                        s_bte_o,
    input  logic                              s_ack_i,
    input  logic                              s_rty_i,
    input  logic                              s_err_i,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    output logic [NUM_MASTERS-1:0]            grant_o,
    output logic                              busy_o
);
    localparam int SW     = DATA_WIDTH / 8;
    localparam int GW     = $clog2(NUM_MASTERS);
    localparam int TW_RAW = $clog2(TIMEOUT + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 32) ? 32 : TW_RAW);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                   r_state, w_state_nxt;
    logic [GW-1:0]            r_gnt, w_gnt_nxt;
    logic [GW-1:0]            r_rr_ptr, w_ptr_nxt;
    logic [TW-1:0]            r_tmo;
    logic [2*NUM_MASTERS-1:0] w_dbl;
    logic [GW-1:0]            w_off, w_sel;
    logic [GW:0]              w_sum;
    logic                     w_active, w_resp, w_tmo_hit;
    logic [ADDR_WIDTH-1:0]    w_adr;
    logic [DATA_WIDTH-1:0]    w_dat;
    logic [SW-1:0]            w_sel_b;
    logic                     w_cyc, w_stb, w_we, w_cab;
    logic [2:0]               w_cti;
    logic [1:0]               w_bte;

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner's offset.
    assign w_dbl = {m_cyc_i, m_cyc_i} >> r_rr_ptr;
    always_comb begin
        w_off = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--)
            if (w_dbl[i]) w_off = GW'(i);
    end
    assign w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_sel = (w_sum >= (GW+1)'(NUM_MASTERS)) ? GW'(w_sum - (GW+1)'(NUM_MASTERS))
                                                   : GW'(w_sum);

    always_comb begin
        w_adr = '0; w_dat = '0; w_sel_b = '0; w_cyc = 1'b0; w_stb = 1'b0;
        w_we = 1'b0; w_cab = 1'b0; w_cti = '0; w_bte = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_gnt == GW'(i)) begin
                w_adr   = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_dat   = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_b = m_sel_i[i*SW +: SW];
                w_cyc   = m_cyc_i[i];
                w_stb   = m_stb_i[i];
                w_we    = m_we_i[i];
                w_cab   = m_cab_i[i];
                w_cti   = m_cti_i[i*3 +: 3];
                w_bte   = m_bte_i[i*2 +: 2];
            end
        end
    end

    assign w_active  = (r_state == ACTIVE);
    assign w_resp    = s_ack_i | s_rty_i | s_err_i;
    assign w_tmo_hit = (TIMEOUT > 0) && w_active && (r_tmo == TW'(TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_rr_ptr;
        case (r_state)
            IDLE: if (|m_cyc_i) begin
                w_state_nxt = ACTIVE;
                w_gnt_nxt   = w_sel;
            end
            ACTIVE: if (!w_cyc) begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_ptr_nxt   = (r_gnt == GW'(NUM_MASTERS - 1)) ? '0 : r_gnt + GW'(1);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= '0;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_rr_ptr <= w_ptr_nxt;
            if (TIMEOUT > 0 && w_active && w_stb && !w_resp && !w_tmo_hit)
                r_tmo <= (r_tmo < TW'(TIMEOUT)) ? r_tmo + TW'(1) : r_tmo;
            else
                r_tmo <= '0;
        end
    end

    assign s_adr_o = w_active ? w_adr   : '0;
    assign s_dat_o = w_active ? w_dat   : '0;
    assign s_sel_o = w_active ? w_sel_b : '0;
    assign s_we_o  = w_active & w_we;
    assign s_cab_o = w_active & w_cab;
    assign s_cti_o = w_active ? w_cti   : '0;
    assign s_bte_o = w_active ? w_bte   : '0;
    assign s_cyc_o = w_active & w_cyc & ~w_tmo_hit;
    assign s_stb_o = w_active & w_stb & ~w_tmo_hit;
    assign busy_o  = w_active;
    assign m_dat_o = {NUM_MASTERS{s_dat_i}};

    // Slave responses are masked in the cycle the timeout forces its own error.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            grant_o[i] = w_active && (r_gnt == GW'(i));
            m_ack_o[i] = grant_o[i] && !w_tmo_hit && s_ack_i;
            m_rty_o[i] = grant_o[i] && !w_tmo_hit && s_rty_i;
            m_err_o[i] = grant_o[i] && (w_tmo_hit || s_err_i);
        end
    end
endmodule

// File: tb/tb_wb_ext_rr_arbiter.sv
// Directed bench for wb_ext_rr_arbiter: one task per scenario, inline checks.
module tb_wb_ext_rr_arbiter;
    localparam int N = 9, AW = 32, DW = 32;

    logic            clk = 1'b0, rst = 1'b0;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N*DW/8-1:0] m_sel_i;
    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i, m_cab_i;
    logic [N*3-1:0]  m_cti_i;
    logic [N*2-1:0]  m_bte_i;
    logic [N-1:0]    m_ack_o, m_rty_o, m_err_o;
    logic [N*DW-1:0] m_dat_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o, s_dat_i;
    logic [DW/8-1:0] s_sel_o;
    logic            s_cyc_o, s_stb_o, s_we_o, s_cab_o;
    logic [2:0]      s_cti_o;
    logic [1:0]      s_bte_o;
    logic            s_ack_i, s_rty_i, s_err_i;
    logic [N-1:0]    grant_o;
    logic            busy_o;

    int errors = 0;
    int checks = 0;

    wb_ext_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_cab_i(m_cab_i),
        .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_ack_o(m_ack_o), .m_rty_o(m_rty_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cab_o(s_cab_o), .s_cti_o(s_cti_o),
        .s_bte_o(s_bte_o), .s_ack_i(s_ack_i), .s_rty_i(s_rty_i), .s_err_i(s_err_i),
        .s_dat_i(s_dat_i), .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_cyc_i = '0; m_stb_i = '0;
        m_we_i = '0; m_cab_i = '0; m_cti_i = '0; m_bte_i = '0;
        s_ack_i = 1'b0; s_rty_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        m_cyc_i = 9'h1FF; m_stb_i = 9'h1FF;
        tick();
        checks++;
        if (grant_o !== 9'h000 || busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_grant grant=%h busy=%b exp 000/0", grant_o, busy_o);
        end
        checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m_ack_o !== 9'h000 || m_err_o !== 9'h000) begin
            errors++; $display("FAIL reset_outputs cyc=%b stb=%b ack=%h err=%h exp all 0",
                               s_cyc_o, s_stb_o, m_ack_o, m_err_o);
        end
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1; m_adr_i[2*AW +: AW] = 32'h0000_1000;
        #1;
        checks++;
        if (grant_o !== 9'h000 || s_stb_o !== 1'b0) begin
            errors++; $display("FAIL single_idle grant=%h stb=%b exp 000/0", grant_o, s_stb_o);
        end
        tick();
        checks++;
        if (grant_o !== 9'h004 || busy_o !== 1'b1) begin
            errors++; $display("FAIL single_grant grant=%h busy=%b exp 004/1", grant_o, busy_o);
        end
        checks++;
        if (s_adr_o !== 32'h0000_1000 || s_stb_o !== 1'b1) begin
            errors++; $display("FAIL single_pass adr=%h stb=%b exp 00001000/1", s_adr_o, s_stb_o);
        end
        tick();
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
        #1;
        checks++;
        if (m_ack_o !== 9'h004 || m_dat_o[2*DW +: DW] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_ack ack=%h dat=%h exp 004/deadbeef",
                               m_ack_o, m_dat_o[2*DW +: DW]);
        end
        m_cyc_i[2] = 1'b0; m_stb_i[2] = 1'b0;
        tick();
        s_ack_i = 1'b0;
        #1;
        checks++;
        if (grant_o !== 9'h000 || busy_o !== 1'b0 || m_ack_o !== 9'h000) begin
            errors++; $display("FAIL single_release grant=%h busy=%b ack=%h exp 000/0/000",
                               grant_o, busy_o, m_ack_o);
        end
    endtask

    task automatic test_contention();
        do_reset();
        m_cyc_i = 9'h009; m_stb_i = 9'h009;
        tick();
        checks++;
        if (grant_o !== 9'h001) begin
            errors++; $display("FAIL contend_first grant=%h exp 001", grant_o);
        end
        s_ack_i = 1'b1;
        #1;
        checks++;
        if (m_ack_o !== 9'h001) begin
            errors++; $display("FAIL contend_ack ack=%h exp 001", m_ack_o);
        end
        m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
        tick();
        s_ack_i = 1'b0;
        checks++;
        if (grant_o !== 9'h000) begin
            errors++; $display("FAIL contend_gap grant=%h exp 000", grant_o);
        end
        tick();
        checks++;
        if (grant_o !== 9'h008) begin
            errors++; $display("FAIL contend_second grant=%h exp 008", grant_o);
        end
        m_cyc_i = '0; m_stb_i = '0;
        tick();
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_g;
        int g;
        do_reset();
        m_cyc_i = 9'h1FF; m_stb_i = 9'h1FF;
        for (int k = 0; k < 10; k++) begin
            g = k % N;
            exp_g = '0;
            exp_g[g] = 1'b1;
            tick();
            checks++;
            if (grant_o !== exp_g) begin
                errors++; $display("FAIL fair_order_%0d grant=%h exp %h", k, grant_o, exp_g);
            end
            s_ack_i = 1'b1;
            m_cyc_i[g] = 1'b0; m_stb_i[g] = 1'b0;
            tick();
            s_ack_i = 1'b0;
            m_cyc_i[g] = 1'b1; m_stb_i[g] = 1'b1;
        end
        m_cyc_i = '0; m_stb_i = '0;
        tick();
    endtask

    task automatic test_burst_hold();
        do_reset();
        m_cyc_i[5] = 1'b1; m_stb_i[5] = 1'b1; m_cti_i[5*3 +: 3] = 3'b010;
        tick();
        checks++;
        if (grant_o !== 9'h020 || s_cti_o !== 3'b010) begin
            errors++; $display("FAIL burst_grant grant=%h cti=%b exp 020/010", grant_o, s_cti_o);
        end
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s_ack_i = 1'b1;
            if (b == 3) begin
                m_cti_i[5*3 +: 3] = 3'b111;
                m_cyc_i[5] = 1'b0; m_stb_i[5] = 1'b0;
            end
            #1;
            checks++;
            if (m_ack_o !== 9'h020 || grant_o !== 9'h020) begin
                errors++; $display("FAIL burst_beat_%0d ack=%h grant=%h exp 020/020", b, m_ack_o, grant_o);
            end
            tick();
        end
        s_ack_i = 1'b0;
        checks++;
        if (grant_o !== 9'h000 || m_ack_o !== 9'h000) begin
            errors++; $display("FAIL burst_gap grant=%h ack=%h exp 000/000", grant_o, m_ack_o);
        end
        tick();
        checks++;
        if (grant_o !== 9'h002) begin
            errors++; $display("FAIL burst_next grant=%h exp 002", grant_o);
        end
        m_cyc_i = '0; m_stb_i = '0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        m_cyc_i[4] = 1'b1; m_stb_i[4] = 1'b1;
        tick();
        checks++;
        if (s_stb_o !== 1'b1 || grant_o !== 9'h010) begin
            errors++; $display("FAIL tmo_start stb=%b grant=%h exp 1/010", s_stb_o, grant_o);
        end
        for (int c = 1; c < 16; c++) tick();
        checks++;
        if (m_err_o !== 9'h000 || s_stb_o !== 1'b1) begin
            errors++; $display("FAIL tmo_early err=%h stb=%b exp 000/1", m_err_o, s_stb_o);
        end
        tick();
        checks++;
        if (m_err_o !== 9'h010 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0) begin
            errors++; $display("FAIL tmo_fire err=%h stb=%b cyc=%b exp 010/0/0",
                               m_err_o, s_stb_o, s_cyc_o);
        end
        tick();
        checks++;
        if (m_err_o !== 9'h000 || s_stb_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++; $display("FAIL tmo_after err=%h stb=%b busy=%b exp 000/1/1",
                               m_err_o, s_stb_o, busy_o);
        end
        m_cyc_i = '0; m_stb_i = '0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m_cyc_i[6] = 1'b1; m_stb_i[6] = 1'b1; m_cti_i[6*3 +: 3] = 3'b010;
        tick();
        s_ack_i = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || grant_o !== 9'h000 || busy_o !== 1'b0 || m_ack_o !== 9'h000) begin
            errors++; $display("FAIL rst_mid cyc=%b grant=%h busy=%b ack=%h exp 0/000/0/000",
                               s_cyc_o, grant_o, busy_o, m_ack_o);
        end
        clear_inputs();
        tick();
        rst = 1'b0;
        m_cyc_i[7] = 1'b1; m_stb_i[7] = 1'b1;
        tick();
        checks++;
        if (grant_o !== 9'h080 || s_stb_o !== 1'b1) begin
            errors++; $display("FAIL rst_regrant grant=%h stb=%b exp 080/1", grant_o, s_stb_o);
        end
        m_cyc_i[7] = 1'b0; m_stb_i[7] = 1'b0; m_cyc_i[0] = 1'b1; m_cyc_i[8] = 1'b1;
        tick();
        tick();
        checks++;
        if (grant_o !== 9'h100) begin
            errors++; $display("FAIL rst_ptr_wrap grant=%h exp 100", grant_o);
        end
        m_cyc_i = '0;
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_fairness();
        test_burst_hold();
        test_timeout();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
